// File: rtl/login_controller.sv
// Login sequencer: gathers a user name one character per cycle, runs a single
// CAM lookup on submit, reports grant/deny and enforces a timed lockout.
module login_controller #(
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_in,
  input  logic        submit,
  input  logic        clear,
  output logic [3:0]  cam_data_len,
  output logic [63:0] cam_data,
  input  logic        cam_valid,
  input  logic [2:0]  cam_addr,
  output logic        result_valid,
  output logic        granted,
  output logic [2:0]  user_id,
  output logic [3:0]  fail_count,
  output logic        locked,
  output logic        busy
);

  typedef enum logic [1:0] {COLLECT, LOOKUP, LOCKOUT} state_t;

  localparam logic [3:0]  MAX_F     = 4'(MAX_FAILS);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

  state_t      state, state_nx;
  logic [63:0] name_q, name_nx;
  logic [3:0]  len_q, len_nx;
  logic        ovf_q, ovf_nx;
  logic [15:0] lock_q, lock_nx;
  logic        granted_nx;
  logic [2:0]  user_nx;
  logic [3:0]  fail_nx;
  logic        rv_nx;
  logic        match;
  logic [3:0]  fail_inc;

  assign cam_data     = name_q;
  assign cam_data_len = len_q;
  assign busy         = (state != COLLECT);
  assign match        = cam_valid && !ovf_q;
  assign fail_inc     = fail_count + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= COLLECT;
      name_q       <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      lock_q       <= '0;
      granted      <= 1'b0;
      user_id      <= '0;
      fail_count   <= '0;
      result_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_nx;
      name_q       <= name_nx;
      len_q        <= len_nx;
      ovf_q        <= ovf_nx;
      lock_q       <= lock_nx;
      granted      <= granted_nx;
      user_id      <= user_nx;
      fail_count   <= fail_nx;
      result_valid <= rv_nx;
      // locked trails the state by one cycle so it rises after the failing result
      locked       <= (state == LOCKOUT);
    end
  end

  always_comb begin
    state_nx   = state;
    name_nx    = name_q;
    len_nx     = len_q;
    ovf_nx     = ovf_q;
    lock_nx    = lock_q;
    granted_nx = granted;
    user_nx    = user_id;
    fail_nx    = fail_count;
    rv_nx      = 1'b0;

    case (state)
      COLLECT: begin
        if (clear) begin
          name_nx    = '0;
          len_nx     = '0;
          ovf_nx     = 1'b0;
          granted_nx = 1'b0;
          user_nx    = '0;
        end else if (submit) begin
          if (len_q != 4'd0 || ovf_q) begin
            granted_nx = 1'b0;
            user_nx    = '0;
            state_nx   = LOOKUP;
          end
        end else if (char_valid) begin
          if (len_q < 4'd8) begin
            name_nx[{len_q[2:0], 3'b000} +: 8] = char_in;
            len_nx = len_q + 4'd1;
          end else begin
            ovf_nx = 1'b1;
          end
        end
      end

      LOOKUP: begin
        rv_nx      = 1'b1;
        granted_nx = match;
        user_nx    = match ? cam_addr : 3'd0;
        name_nx    = '0;
        len_nx     = '0;
        ovf_nx     = 1'b0;
        if (match) begin
          fail_nx  = '0;
          state_nx = COLLECT;
        end else begin
          fail_nx  = fail_inc;
          state_nx = (fail_inc == MAX_F) ? LOCKOUT : COLLECT;
        end
      end

      LOCKOUT: begin
        if (lock_q == LOCK_LAST) begin
          lock_nx  = '0;
          fail_nx  = '0;
          state_nx = COLLECT;
        end else begin
          lock_nx = lock_q + 16'd1;
        end
      end

      default: state_nx = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_login_controller.sv
// Self-checking bench for login_controller: directed attempt table, hand-written
// lockout/reset sequences and random traffic checked against a queue-based model.
module tb_login_controller;

  localparam int MAX_FAILS   = 3;
  localparam int LOCK_CYCLES = 16;

  logic        clk = 1'b0;
  logic        reset, char_valid, submit, clear;
  logic [7:0]  char_in;
  logic [3:0]  cam_data_len;
  logic [63:0] cam_data;
  logic        cam_valid;
  logic [2:0]  cam_addr;
  logic        result_valid, granted, locked, busy;
  logic [2:0]  user_id;
  logic [3:0]  fail_count;

  int n_vec = 0;
  int n_err = 0;

  string cam_names [8] = '{"LEO", "MAX", "AARONAAR", "ZOE", "CLAIRE", "BOB", "EVE", "RYAN"};

  // reference model state
  logic [7:0] m_buf [$];
  bit         m_ovf, m_lookup, m_granted, m_rv, m_locked;
  int         m_fails, m_lock_left, m_user;

  typedef struct {
    string       name;
    bit          z_on_submit;
    logic [3:0]  exp_len;
    logic [63:0] exp_data;
    bit          exp_granted;
    logic [2:0]  exp_user;
    logic [3:0]  exp_fails;
  } attempt_t;

  attempt_t tbl [5];

  login_controller #(.MAX_FAILS(MAX_FAILS), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char_in(char_in),
    .submit(submit), .clear(clear), .cam_data_len(cam_data_len), .cam_data(cam_data),
    .cam_valid(cam_valid), .cam_addr(cam_addr), .result_valid(result_valid),
    .granted(granted), .user_id(user_id), .fail_count(fail_count),
    .locked(locked), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [67:0] pack_name(string s);
    logic [63:0] d = '0;
    int n = (s.len() > 8) ? 8 : s.len();
    for (int i = 0; i < n; i++) d[8*i +: 8] = s[i];
    return {4'(n), d};
  endfunction

  // behavioural CAM seen by the DUT
  always_comb begin
    cam_valid = 1'b0;
    cam_addr  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!cam_valid && pack_name(cam_names[i]) == {cam_data_len, cam_data}) begin
        cam_valid = 1'b1;
        cam_addr  = 3'(i);
      end
    end
  end

  task automatic check_val(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit cv, input logic [7:0] ch, input bit sub, input bit clr, input bit rst);
    bit hit, same;
    int idx;
    if (rst) begin
      m_buf.delete();
      m_ovf = 0; m_lookup = 0; m_granted = 0; m_rv = 0; m_locked = 0;
      m_fails = 0; m_lock_left = 0; m_user = 0;
    end else begin
      m_locked = (m_lock_left > 0);
      m_rv = 0;
      if (m_lookup) begin
        hit = 0; idx = 0;
        for (int i = 0; i < 8; i++) begin
          same = (cam_names[i].len() == m_buf.size());
          for (int j = 0; same && j < m_buf.size(); j++)
            if (m_buf[j] != cam_names[i][j]) same = 0;
          if (same && !hit) begin hit = 1; idx = i; end
        end
        hit = hit && !m_ovf;
        m_rv = 1; m_granted = hit; m_user = hit ? idx : 0;
        m_buf.delete(); m_ovf = 0; m_lookup = 0;
        if (hit) m_fails = 0;
        else begin
          m_fails++;
          if (m_fails == MAX_FAILS) m_lock_left = LOCK_CYCLES;
        end
      end else if (m_lock_left > 0) begin
        m_lock_left--;
        if (m_lock_left == 0) m_fails = 0;
      end else if (clr) begin
        m_buf.delete(); m_ovf = 0; m_granted = 0; m_user = 0;
      end else if (sub) begin
        if (m_buf.size() > 0 || m_ovf) begin
          m_granted = 0; m_user = 0; m_lookup = 1;
        end
      end else if (cv) begin
        if (m_buf.size() < 8) m_buf.push_back(ch);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check_output();
    logic [63:0] d = '0;
    for (int i = 0; i < m_buf.size(); i++) d[8*i +: 8] = m_buf[i];
    check_val("result_valid", 64'(result_valid), 64'(m_rv));
    check_val("granted", 64'(granted), 64'(m_granted));
    check_val("user_id", 64'(user_id), 64'(m_user));
    check_val("fail_count", 64'(fail_count), 64'(m_fails));
    check_val("locked", 64'(locked), 64'(m_locked));
    check_val("busy", 64'(busy), 64'(m_lookup || m_lock_left > 0));
    check_val("cam_data_len", 64'(cam_data_len), 64'(m_buf.size()));
    check_val("cam_data", cam_data, d);
  endtask

  // drive one cycle of inputs, clock it, update the model, compare after the edge
  task automatic apply_stimulus(input bit cv, input logic [7:0] ch, input bit sub, input bit clr, input bit rst);
    char_valid = cv; char_in = ch; submit = sub; clear = clr; reset = rst;
    @(posedge clk);
    #1;
    model_step(cv, ch, sub, clr, rst);
    check_output();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 8'h00, 0, 0, 0);
  endtask

  task automatic run_attempt(input string s, input bit z,
                             output logic rv, output logic g, output logic [2:0] u,
                             output logic [3:0] f, output logic [3:0] lk_len,
                             output logic [63:0] lk_data);
    for (int i = 0; i < s.len(); i++) apply_stimulus(1, s[i], 0, 0, 0);
    apply_stimulus(z, 8'h5A, 1, 0, 0);
    lk_len = cam_data_len; lk_data = cam_data;
    apply_stimulus(0, 8'h00, 0, 0, 0);
    rv = result_valid; g = granted; u = user_id; f = fail_count;
  endtask

  initial begin
    logic        rv, g;
    logic [2:0]  u;
    logic [3:0]  f, lk_len;
    logic [63:0] lk_data;
    int          lk_cnt, lk_first, rv_seen;
    string       s;
    int          pos;
    string       pool [12] = '{"LEO", "MAX", "AARONAAR", "ZOE", "CLAIRE", "BOB", "EVE",
                               "RYAN", "LEX", "AARONAARO", "CLAIR", "X"};

    tbl[0] = '{"LEO",       0, 4'd3, 64'h00000000004F454C, 1, 3'd0, 4'd0};
    tbl[1] = '{"CLAIRE",    1, 4'd6, 64'h0000455249414C43, 1, 3'd4, 4'd0};
    tbl[2] = '{"AARONAARO", 0, 4'd8, 64'h5241414E4F524141, 0, 3'd0, 4'd1};
    tbl[3] = '{"LEX",       0, 4'd3, 64'h000000000058454C, 0, 3'd0, 4'd2};
    tbl[4] = '{"RYAN",      0, 4'd4, 64'h000000004E415952, 1, 3'd7, 4'd0};

    char_valid = 0; char_in = 0; submit = 0; clear = 0; reset = 1;
    apply_stimulus(0, 8'h00, 0, 0, 1);
    apply_stimulus(0, 8'h00, 0, 0, 1);
    check_val("reset_fail_count", 64'(fail_count), 64'd0);
    check_val("reset_busy", 64'(busy), 64'd0);

    for (int k = 0; k < 5; k++) begin
      run_attempt(tbl[k].name, tbl[k].z_on_submit, rv, g, u, f, lk_len, lk_data);
      check_val({"tbl_lookup_len_", tbl[k].name}, 64'(lk_len), 64'(tbl[k].exp_len));
      check_val({"tbl_lookup_data_", tbl[k].name}, lk_data, tbl[k].exp_data);
      check_val({"tbl_result_valid_", tbl[k].name}, 64'(rv), 64'd1);
      check_val({"tbl_granted_", tbl[k].name}, 64'(g), 64'(tbl[k].exp_granted));
      check_val({"tbl_user_id_", tbl[k].name}, 64'(u), 64'(tbl[k].exp_user));
      check_val({"tbl_fail_count_", tbl[k].name}, 64'(f), 64'(tbl[k].exp_fails));
      idle(1);
    end

    // empty submit and clear after two characters
    apply_stimulus(0, 8'h00, 1, 0, 0);
    check_val("empty_submit_busy", 64'(busy), 64'd0);
    apply_stimulus(0, 8'h00, 0, 0, 0);
    check_val("empty_submit_rv", 64'(result_valid), 64'd0);
    apply_stimulus(1, 8'h41, 0, 0, 0);
    apply_stimulus(1, 8'h42, 0, 0, 0);
    check_val("two_chars_len", 64'(cam_data_len), 64'd2);
    apply_stimulus(0, 8'h00, 0, 1, 0);
    check_val("clear_data", cam_data, 64'd0);
    check_val("clear_len", 64'(cam_data_len), 64'd0);

    // three failures trigger a 16-cycle lockout
    for (int k = 1; k <= 3; k++) begin
      run_attempt("LEX", 0, rv, g, u, f, lk_len, lk_data);
      check_val("lex_rv", 64'(rv), 64'd1);
      check_val("lex_granted", 64'(g), 64'd0);
      check_val("lex_fail_count", 64'(f), 64'(k));
    end
    lk_cnt = 0; lk_first = 0; rv_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k >= 2 && k <= 4) apply_stimulus(1, pack_name("LEO") >> (8*(k-2)), 0, 0, 0);
      else if (k == 5)      apply_stimulus(0, 8'h00, 1, 0, 0);
      else                  apply_stimulus(0, 8'h00, 0, 0, 0);
      if (result_valid) rv_seen++;
      if (locked) begin
        lk_cnt++;
        if (lk_first == 0) lk_first = k;
      end else if (lk_cnt > 0) break;
    end
    check_val("lock_first_cycle", 64'(lk_first), 64'd1);
    check_val("lock_duration", 64'(lk_cnt), 64'(LOCK_CYCLES));
    check_val("lock_no_result", 64'(rv_seen), 64'd0);
    check_val("post_lock_fail_count", 64'(fail_count), 64'd0);
    run_attempt("LEO", 0, rv, g, u, f, lk_len, lk_data);
    check_val("post_lock_granted", 64'(g), 64'd1);
    check_val("post_lock_user", 64'(u), 64'd0);

    // reset in the middle of a lookup
    run_attempt("LEX", 0, rv, g, u, f, lk_len, lk_data);
    for (int i = 0; i < 3; i++) apply_stimulus(1, pack_name("LEO") >> (8*i), 0, 0, 0);
    apply_stimulus(0, 8'h00, 1, 0, 0);
    check_val("lookup_busy", 64'(busy), 64'd1);
    apply_stimulus(0, 8'h00, 0, 0, 1);
    check_val("rst_lookup_rv", 64'(result_valid), 64'd0);
    check_val("rst_lookup_fail_count", 64'(fail_count), 64'd0);
    check_val("rst_lookup_busy", 64'(busy), 64'd0);
    apply_stimulus(0, 8'h00, 0, 0, 0);
    check_val("rst_lookup_rv_after", 64'(result_valid), 64'd0);

    // reset at lockout cycle 5
    for (int k = 0; k < 3; k++) run_attempt("LEX", 0, rv, g, u, f, lk_len, lk_data);
    idle(5);
    check_val("pre_rst_locked", 64'(locked), 64'd1);
    apply_stimulus(0, 8'h00, 0, 0, 1);
    check_val("rst_lock_locked", 64'(locked), 64'd0);
    check_val("rst_lock_busy", 64'(busy), 64'd0);
    check_val("rst_lock_fail_count", 64'(fail_count), 64'd0);
    idle(2);

    // random traffic against the model
    for (int a = 0; a < 120; a++) begin
      s = pool[$urandom_range(11)];
      pos = 0;
      for (int c = 0; c < 40; c++) begin
        bit cv, sub, clr, rst;
        cv  = (pos < s.len()) && ($urandom_range(3) != 0);
        sub = (pos >= s.len()) && ($urandom_range(1) == 1);
        clr = ($urandom_range(40) == 0);
        rst = ($urandom_range(300) == 0);
        apply_stimulus(cv, cv ? s[pos] : 8'($urandom), sub, clr, rst);
        if (cv) pos++;
        if (sub) break;
      end
      idle($urandom_range(3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
